// File: rtl/cdb_pkg.sv
// cdb_pkg: shared writeback/CDB widths, requester ids and the CDB beat struct
package cdb_pkg;
    localparam int NUM_REQ = 3;
    localparam int PREG_W  = 7;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 4;
    localparam int IDX_W   = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [IDX_W-1:0] {FU_ALU, FU_BRU, FU_LSU} fu_e;
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
    } cdb_t;
    function automatic idx_t rr_idx(idx_t base, int unsigned off);
        return idx_t'((32'(base) + off) % NUM_REQ);
    endfunction
endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// wb_cdb_arbiter_if: functional-unit result requests and the registered CDB beat
interface wb_cdb_arbiter_if;
    import cdb_pkg::*;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][PREG_W-1:0] req_preg;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0][ROB_W-1:0]  req_rob;
    logic                           cdb_valid;
    logic                           cdb_we;
    logic [PREG_W-1:0]              cdb_preg;
    logic [DATA_W-1:0]              cdb_data;
    logic [ROB_W-1:0]               cdb_rob;
    modport master (
        input  req_valid, req_we, req_preg, req_data, req_rob,
        output req_ready, cdb_valid, cdb_we, cdb_preg, cdb_data, cdb_rob
    );
    modport slave (
        output req_valid, req_we, req_preg, req_data, req_rob,
        input  req_ready, cdb_valid, cdb_we, cdb_preg, cdb_data, cdb_rob
    );
endinterface

// File: rtl/wb_cdb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting the scan at ptr
module rr_arbiter import cdb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               ptr,
    output logic [NUM_REQ-1:0] gnt,
    output idx_t               idx,
    output logic               any
);
    // first requester found scanning ptr, ptr+1, ... wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any && req[rr_idx(ptr, k)]) begin
                any = 1'b1;
                idx = rr_idx(ptr, k);
                gnt[rr_idx(ptr, k)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_cdb_arbiter.sv
// wb_cdb_arbiter: round-robin writeback arbiter driving the registered CDB beat
module wb_cdb_arbiter import cdb_pkg::*; (
    input logic              clk,
    input logic              reset,
    input logic              flush,
    wb_cdb_arbiter_if.master bus
);
    idx_t               rr_ptr;
    idx_t               idx;
    logic               any;
    logic [NUM_REQ-1:0] req_gated;
    logic [NUM_REQ-1:0] gnt;
    cdb_t               cdb_q;
    assign req_gated = bus.req_valid & {NUM_REQ{reset & ~flush}};
    rr_arbiter u_rr (
        .req (req_gated),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );
    assign bus.req_ready = gnt;
    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_we    = cdb_q.we;
    assign bus.cdb_preg  = cdb_q.preg;
    assign bus.cdb_data  = cdb_q.data;
    assign bus.cdb_rob   = cdb_q.rob;
    // advance pointer past the winner and capture its result; writes to x0 never reach the PRF
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            cdb_q  <= '0;
        end else begin
            if (any) rr_ptr <= rr_idx(idx, 1);
            cdb_q.valid <= any;
            cdb_q.we    <= any && bus.req_we[idx] && (bus.req_preg[idx] != '0);
            if (any) begin
                cdb_q.preg <= bus.req_preg[idx];
                cdb_q.data <= bus.req_data[idx];
                cdb_q.rob  <= bus.req_rob[idx];
            end
        end
    end
endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// tb_wb_cdb_arbiter: scoreboard bench with directed and randomized writeback traffic
module tb_wb_cdb_arbiter;
    import cdb_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int mptr = 0;
    int last_g = -1;
    int waits [NUM_REQ];
    cdb_t exp_q [$];
    wb_cdb_arbiter_if bus ();
    wb_cdb_arbiter dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_req(int i, logic v, logic we, logic [PREG_W-1:0] p, logic [DATA_W-1:0] d,
                           logic [ROB_W-1:0] r);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_preg[i]  = p;
        bus.req_data[i]  = d;
        bus.req_rob[i]   = r;
    endtask

    // inputs were set just after a negedge; check grant, push the expected beat, wait a cycle
    task automatic cycle();
        int g;
        cdb_t e;
        logic [NUM_REQ-1:0] exp_rdy;
        #1;
        g = -1;
        if (reset && !flush)
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && bus.req_valid[(mptr + k) % NUM_REQ]) g = (mptr + k) % NUM_REQ;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset && !flush && bus.req_valid[i]) begin
                if (bus.req_ready[i]) begin
                    check("fairness", 64'(waits[i] < NUM_REQ), 64'(1));
                    waits[i] = 0;
                end else waits[i]++;
            end
        end
        e = '0;
        if (g >= 0) begin
            e.valid = 1'b1;
            e.we    = bus.req_we[g] && (bus.req_preg[g] != 0);
            e.preg  = bus.req_preg[g];
            e.data  = bus.req_data[g];
            e.rob   = bus.req_rob[g];
            mptr    = (g + 1) % NUM_REQ;
        end
        if (reset) exp_q.push_back(e);
        last_g = g;
        @(negedge clk);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_cdb_valid"}, 64'(bus.cdb_valid), 64'(0));
        check({tag, "_cdb_we"}, 64'(bus.cdb_we), 64'(0));
        check({tag, "_cdb_preg"}, 64'(bus.cdb_preg), 64'(0));
        check({tag, "_cdb_data"}, 64'(bus.cdb_data), 64'(0));
        check({tag, "_cdb_rob"}, 64'(bus.cdb_rob), 64'(0));
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    endtask

    // monitor: every beat slot after an edge is compared against the oldest expectation
    initial begin
        cdb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cdb_valid", 64'(bus.cdb_valid), 64'(e.valid));
                check("cdb_we", 64'(bus.cdb_we), 64'(e.we));
                if (e.valid) begin
                    check("cdb_preg", 64'(bus.cdb_preg), 64'(e.preg));
                    check("cdb_data", 64'(bus.cdb_data), 64'(e.data));
                    check("cdb_rob", 64'(bus.cdb_rob), 64'(e.rob));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            waits[i] = 0;
            set_req(i, 1'b0, 1'b0, '0, '0, '0);
        end
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        // single LSU requester, then idle
        set_req(FU_LSU, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 4'd3);
        cycle();
        bus.req_valid = '0;
        cycle();
        // all valid for six cycles: 0,1,2,0,1,2
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 7'(10 + i), 32'(32'h100 * (i + 1)), 4'(i));
        repeat (6) cycle();
        bus.req_valid = '0;
        // x0 suppression and no-rd result
        set_req(FU_ALU, 1'b1, 1'b1, 7'd0, 32'h1234, 4'd7);
        cycle();
        bus.req_valid = '0;
        set_req(FU_BRU, 1'b1, 1'b0, 7'd9, 32'h5678, 4'd8);
        cycle();
        bus.req_valid = '0;
        // beat issued before flush, flush with ALU+BRU valid, then resume at BRU
        set_req(FU_ALU, 1'b1, 1'b1, 7'd20, 32'hAAAA5555, 4'd1);
        cycle();
        set_req(FU_BRU, 1'b1, 1'b1, 7'd21, 32'h0BADF00D, 4'd2);
        flush = 1'b1;
        cycle();
        cycle();
        flush = 1'b0;
        cycle();
        bus.req_valid = '0;
        cycle();
        // randomized traffic: units hold until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_g == i || !bus.req_valid[i]) begin
                    set_req(i, $urandom_range(0, 9) < 6, 1'($urandom),
                            ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom),
                            $urandom, 4'($urandom));
                    if (last_g == i) waits[i] = 0;
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            cycle();
        end
        flush = 1'b0;
        // asynchronous reset between edges with everything valid
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 7'(40 + i), 32'hC0DE0000 + i, 4'(9 + i));
        cycle();
        #2;
        reset = 1'b0;
        exp_q.delete();
        mptr = 0;
        for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        cycle();
        reset = 1'b1;
        cycle();
        cycle();
        bus.req_valid = '0;
        cycle();
        cycle();
        check("drain", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
